// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector between two FWFT FIFOs.
// One pixel in and one pixel out per cycle, with saturated-magnitude or binary-threshold output.
module sobel_stream #(
    parameter int IMG_WIDTH  = 540,
    parameter int IMG_HEIGHT = 720,
    parameter int PIX_W      = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mode,
    input  logic [PIX_W+2:0] threshold,
    output logic             in_rd_en,
    input  logic             in_empty,
    input  logic [PIX_W-1:0] in_dout,
    output logic             out_wr_en,
    input  logic             out_full,
    output logic [PIX_W-1:0] out_din,
    output logic             done
);
    localparam int N       = IMG_WIDTH * IMG_HEIGHT;
    localparam int BUF_LEN = 2 * IMG_WIDTH + 2;
    localparam int CNT_W   = $clog2(N);
    localparam int COL_W   = $clog2(IMG_WIDTH);
    localparam int ROW_W   = $clog2(IMG_HEIGHT);
    localparam int GW      = PIX_W + 3;
    localparam logic [GW:0]      PIX_MAX  = {4'b0000, {PIX_W{1'b1}}};
    localparam logic [CNT_W-1:0] FILL_END = CNT_W'(IMG_WIDTH);
    localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(N - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {FILL = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   in_cnt_reg;
    logic [COL_W-1:0]   out_col_reg;
    logic [ROW_W-1:0]   out_row_reg;
    logic               mode_reg;
    logic [PIX_W+2:0]   thr_reg;
    logic [PIX_W-1:0]   pix_buf [0:BUF_LEN-1];
    logic               last_out;
    logic               run_go;
    logic               border;
    logic [PIX_W-1:0]   p00, p01, p02, p10, p12, p20, p21, p22;
    logic [GW-1:0]      gx_pos, gx_neg, gy_pos, gy_neg, gx, gy, gx_abs, gy_abs;
    logic [GW:0]        mag;
    logic [PIX_W-1:0]   edge_pix;

    assign last_out = (out_row_reg == LAST_ROW) && (out_col_reg == LAST_COL);
    assign run_go   = !in_empty && !out_full;
    assign border   = (out_row_reg == '0) || (out_row_reg == LAST_ROW) ||
                      (out_col_reg == '0) || (out_col_reg == LAST_COL);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FILL:    if (!in_empty && in_cnt_reg == FILL_END) state_next = RUN;
            RUN:     if (run_go && in_cnt_reg == LAST_IN) state_next = FLUSH;
            FLUSH:   if (!out_full && last_out) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        out_din   = '0;
        case (state_reg)
            FILL: in_rd_en = !in_empty;
            RUN: begin
                in_rd_en  = run_go;
                out_wr_en = run_go;
                if (run_go) out_din = edge_pix;
            end
            FLUSH:   out_wr_en = !out_full;
            default: ;
        endcase
    end

    // pix_buf[m] holds the input popped m+1 pops ago; in_dout is the newest window tap
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BUF_LEN; i++) pix_buf[i] <= '0;
        end else if (in_rd_en) begin
            pix_buf[0] <= in_dout;
            for (int i = 1; i < BUF_LEN; i++) pix_buf[i] <= pix_buf[i-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_cnt_reg  <= '0;
            out_col_reg <= '0;
            out_row_reg <= '0;
            mode_reg    <= 1'b0;
            thr_reg     <= '0;
            done        <= 1'b0;
        end else begin
            done <= (state_reg == FLUSH) && out_wr_en && last_out;
            if (in_rd_en) begin
                if (state_reg == FILL && in_cnt_reg == '0) begin
                    mode_reg <= mode;
                    thr_reg  <= threshold;
                end
                in_cnt_reg <= (in_cnt_reg == LAST_IN) ? '0 : in_cnt_reg + CNT_W'(1);
            end
            if (out_wr_en) begin
                if (out_col_reg == LAST_COL) begin
                    out_col_reg <= '0;
                    out_row_reg <= (out_row_reg == LAST_ROW) ? '0 : out_row_reg + ROW_W'(1);
                end else begin
                    out_col_reg <= out_col_reg + COL_W'(1);
                end
            end
        end
    end

    // Window taps relative to the pop of input k+W+1, which produces output k
    assign p22 = in_dout;
    assign p21 = pix_buf[0];
    assign p20 = pix_buf[1];
    assign p12 = pix_buf[IMG_WIDTH-1];
    assign p10 = pix_buf[IMG_WIDTH+1];
    assign p02 = pix_buf[2*IMG_WIDTH-1];
    assign p01 = pix_buf[2*IMG_WIDTH];
    assign p00 = pix_buf[2*IMG_WIDTH+1];

    always_comb begin
        gx_pos   = {3'b000, p02} + {2'b00, p12, 1'b0} + {3'b000, p22};
        gx_neg   = {3'b000, p00} + {2'b00, p10, 1'b0} + {3'b000, p20};
        gy_pos   = {3'b000, p20} + {2'b00, p21, 1'b0} + {3'b000, p22};
        gy_neg   = {3'b000, p00} + {2'b00, p01, 1'b0} + {3'b000, p02};
        gx       = gx_pos - gx_neg;
        gy       = gy_pos - gy_neg;
        gx_abs   = gx[GW-1] ? (~gx + GW'(1)) : gx;
        gy_abs   = gy[GW-1] ? (~gy + GW'(1)) : gy;
        mag      = {1'b0, gx_abs} + {1'b0, gy_abs};
        edge_pix = '0;
        if (!border) begin
            if (mode_reg) edge_pix = (mag > {1'b0, thr_reg}) ? {PIX_W{1'b1}} : '0;
            else          edge_pix = (mag > PIX_MAX) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];
        end
    end
endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream (8x6 frames): models both FIFOs, checks pixel streams,
// pop/push handshake rules, latency, done pulses, mid-frame reset and back-to-back frames.
module tb_sobel_stream;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mode = 1'b0;
    logic [10:0] threshold = '0;
    logic        in_rd_en;
    logic        in_empty = 1'b1;
    logic [7:0]  in_dout = '0;
    logic        out_wr_en;
    logic        out_full = 1'b0;
    logic [7:0]  out_din;
    logic        done;

    int in_q[$];
    int out_q[$];
    int pops, pushes, dones, cyc, first_push_cyc, last_push_cyc, done_cyc, viol;
    int compared = 0;
    int mismatched = 0;

    sobel_stream #(.IMG_WIDTH(8), .IMG_HEIGHT(6), .PIX_W(8)) dut (
        .clock(clock), .reset(reset), .mode(mode), .threshold(threshold),
        .in_rd_en(in_rd_en), .in_empty(in_empty), .in_dout(in_dout),
        .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din), .done(done)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_stats();
        in_q.delete();
        out_q.delete();
        pops = 0; pushes = 0; dones = 0; cyc = 0; viol = 0;
        first_push_cyc = -1; last_push_cyc = -1; done_cyc = -1;
    endtask

    // kind 0: flat 100, kind 1: vertical step at col 4, kind 2: ramp 10*c
    task automatic load_frame(input int kind);
        for (int k = 0; k < 48; k++) begin
            case (kind)
                0:       in_q.push_back(100);
                1:       in_q.push_back(((k % 8) >= 4) ? 255 : 0);
                default: in_q.push_back(10 * (k % 8));
            endcase
        end
    endtask

    function automatic int exp_pix(input int kind, input int k, input bit md, input int thr);
        int r, c;
        r = k / 8;
        c = k % 8;
        if (r == 0 || r == 5 || c == 0 || c == 7) return 0;
        case (kind)
            0:       return 0;
            1:       return (c == 3 || c == 4) ? 255 : 0;
            default: return md ? ((80 > thr) ? 255 : 0) : 80;
        endcase
    endfunction

    task automatic step(input bit stall);
        @(negedge clock);
        in_empty = (in_q.size() == 0) || (stall && $urandom_range(1) == 1);
        in_dout  = (in_q.size() != 0) ? 8'(in_q[0]) : 8'd0;
        out_full = stall && ($urandom_range(1) == 1);
        #1;
        if (done) begin
            dones++;
            done_cyc = cyc;
        end
        if (in_rd_en) begin
            if (in_empty) viol++;
            else begin
                void'(in_q.pop_front());
                pops++;
            end
        end
        if (out_wr_en) begin
            if (out_full) viol++;
            else begin
                out_q.push_back(int'(out_din));
                if (first_push_cyc < 0) first_push_cyc = cyc;
                last_push_cyc = cyc;
                pushes++;
            end
        end
        cyc++;
    endtask

    task automatic run(input string name, input bit stall, input int target, input int max_cyc,
                       input int chg_pop);
        int n;
        n = 0;
        while (dones < target && n < max_cyc) begin
            step(stall);
            n++;
            if (chg_pop >= 0 && pops == chg_pop) begin
                mode = 1'b1;
                threshold = 11'd79;
            end
        end
        compared++;
        if (dones < target) begin
            mismatched++;
            $display("FAIL %s_timeout: dones=%0d required %0d within %0d cycles", name, dones, target, max_cyc);
        end
        for (int i = 0; i < 4; i++) step(1'b0);
    endtask

    task automatic check_frame(input string name, input int kind, input bit md, input int thr,
                               input int base);
        int errs;
        errs = 0;
        compared++;
        if (out_q.size() < base + 48) begin
            mismatched++;
            $display("FAIL %s_count: got %0d pixels required %0d", name, out_q.size(), base + 48);
            return;
        end
        for (int k = 0; k < 48; k++) begin
            int e;
            e = exp_pix(kind, k, md, thr);
            compared++;
            if (out_q[base+k] !== e) begin
                mismatched++;
                errs++;
                $display("FAIL %s_pix%0d: got %0d required %0d", name, k, out_q[base+k], e);
            end
        end
        $display("frame %s: 48 pixels checked, errors %0d", name, errs);
    endtask

    task automatic check_int(input string name, input int got, input int req);
        compared++;
        if (got !== req) begin
            mismatched++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1; in_empty = 1'b1; out_full = 1'b0;
        #1;
        check_int("reset_in_rd_en", int'(in_rd_en), 0);
        check_int("reset_out_wr_en", int'(out_wr_en), 0);
        check_int("reset_out_din", int'(out_din), 0);
        check_int("reset_done", int'(done), 0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_flat();
        clear_stats();
        mode = 1'b0; threshold = '0;
        load_frame(0);
        run("flat", 1'b0, 1, 400, -1);
        check_frame("flat", 0, 1'b0, 0, 0);
        check_int("flat_pops", pops, 48);
        check_int("flat_pushes", pushes, 48);
        check_int("flat_first_push_cyc", first_push_cyc, 9);
        check_int("flat_last_push_cyc", last_push_cyc, 56);
        check_int("flat_done_cyc", done_cyc, last_push_cyc + 1);
        check_int("flat_dones", dones, 1);
    endtask

    task automatic test_step();
        clear_stats();
        mode = 1'b0;
        load_frame(1);
        run("step", 1'b0, 1, 400, -1);
        check_frame("step", 1, 1'b0, 0, 0);
    endtask

    task automatic test_ramp();
        int thr_tab[3] = '{0, 79, 80};
        for (int t = 0; t < 3; t++) begin
            clear_stats();
            mode = (t != 0);
            threshold = 11'(thr_tab[t]);
            load_frame(2);
            run("ramp", 1'b0, 1, 400, -1);
            check_frame($sformatf("ramp_m%0d_t%0d", t != 0, thr_tab[t]), 2, t != 0, thr_tab[t], 0);
        end
    endtask

    task automatic test_stall();
        clear_stats();
        mode = 1'b0;
        load_frame(1);
        run("stall", 1'b1, 1, 2000, -1);
        check_frame("stall", 1, 1'b0, 0, 0);
        check_int("stall_handshake_violations", viol, 0);
        check_int("stall_pushes", pushes, 48);
    endtask

    task automatic test_reset_mid();
        int n;
        clear_stats();
        mode = 1'b0;
        load_frame(1);
        n = 0;
        while (pops < 20 && n < 200) begin
            step(1'b0);
            n++;
        end
        check_int("midreset_pops", pops, 20);
        @(negedge clock);
        reset = 1'b1; in_empty = 1'b1; out_full = 1'b0;
        #1;
        check_int("midreset_out_wr_en", int'(out_wr_en), 0);
        check_int("midreset_done", int'(done), 0);
        @(negedge clock);
        reset = 1'b0;
        clear_stats();
        load_frame(1);
        run("midreset", 1'b0, 1, 400, -1);
        check_frame("after_reset", 1, 1'b0, 0, 0);
        check_int("midreset_dones", dones, 1);
    endtask

    task automatic test_back_to_back();
        clear_stats();
        mode = 1'b0; threshold = '0;
        load_frame(2);
        load_frame(2);
        run("b2b", 1'b0, 2, 800, 20);
        check_frame("b2b_frame1", 2, 1'b0, 0, 0);
        check_frame("b2b_frame2", 2, 1'b1, 79, 48);
        check_int("b2b_dones", dones, 2);
        check_int("b2b_pops", pops, 96);
    endtask

    initial begin
        test_reset();
        test_flat();
        test_step();
        test_ramp();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
